// File: rtl/i2c_fmt_fifo.sv
// i2c_fmt_fifo: first-word-fall-through format FIFO feeding the I2C controller FSM
module i2c_fmt_fifo #(
  parameter int FifoDepth = 64,
  localparam int FifoDepthWidth = $clog2(FifoDepth + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wvalid_i,
  output logic                      wready_o,
  input  logic [12:0]               wdata_i,
  input  logic                      flush_i,
  input  logic [FifoDepthWidth-1:0] thresh_i,
  output logic                      fmt_fifo_rvalid_o,
  input  logic                      fmt_fifo_rready_i,
  output logic [FifoDepthWidth-1:0] fmt_fifo_depth_o,
  output logic [7:0]                fmt_byte_o,
  output logic                      fmt_flag_start_before_o,
  output logic                      fmt_flag_stop_after_o,
  output logic                      fmt_flag_read_bytes_o,
  output logic                      fmt_flag_read_continue_o,
  output logic                      fmt_flag_nak_ok_o,
  output logic                      thresh_o,
  output logic                      overflow_o
);
  localparam int PtrWidth = FifoDepth > 1 ? $clog2(FifoDepth) : 1;
  localparam logic [FifoDepthWidth-1:0] Full = FifoDepthWidth'(FifoDepth);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(FifoDepth - 1);
  logic [12:0] mem [FifoDepth];
  logic [PtrWidth-1:0] wptr, rptr;
  logic [FifoDepthWidth-1:0] depth, depth_next;
  logic push, pop, full;
  logic [12:0] head;
  assign full = depth == Full;
  assign wready_o = ~rst_i & ~flush_i & ~full;
  assign fmt_fifo_rvalid_o = depth != '0;
  assign push = wvalid_i & wready_o;
  // flush suppresses the pop so the consumer never sees a handshake that was discarded
  assign pop = fmt_fifo_rvalid_o & fmt_fifo_rready_i & ~flush_i;
  assign fmt_fifo_depth_o = depth;
  // stale memory contents are masked so the head reads as zero when empty
  assign head = fmt_fifo_rvalid_o ? mem[rptr] : '0;
  assign fmt_byte_o = head[7:0];
  assign fmt_flag_start_before_o = head[8];
  assign fmt_flag_stop_after_o = head[9];
  assign fmt_flag_read_bytes_o = head[10];
  assign fmt_flag_read_continue_o = head[11];
  assign fmt_flag_nak_ok_o = head[12];
  // next occupancy: flush wins, simultaneous push and pop cancel out
  always_comb begin
    depth_next = flush_i ? '0 : (push & ~pop) ? depth + 1'b1 : (pop & ~push) ? depth - 1'b1 : depth;
  end
  // pointers wrap explicitly so non-power-of-two depths work
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      depth <= '0;
      thresh_o <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      wptr <= flush_i ? '0 : push ? (wptr == LastPtr ? '0 : wptr + 1'b1) : wptr;
      rptr <= flush_i ? '0 : pop ? (rptr == LastPtr ? '0 : rptr + 1'b1) : rptr;
      depth <= depth_next;
      thresh_o <= depth_next < thresh_i;
      overflow_o <= wvalid_i & ~flush_i & full;
    end
  end
  // entry storage, deliberately not reset; depth alone defines validity
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= wdata_i;
  end
endmodule

// File: tb/tb_i2c_fmt_fifo.sv
// tb_i2c_fmt_fifo: queue-model checker plus directed scenarios for i2c_fmt_fifo
module tb_i2c_fmt_fifo;
  logic clk = 0;
  logic rst_i, wvalid_i, flush_i, rready;
  logic [12:0] wdata_i;
  logic [6:0] thresh_i;
  logic wready_o, rvalid, thresh_o, overflow_o;
  logic [6:0] depth_o;
  logic [7:0] byte_o;
  logic f_start, f_stop, f_rb, f_rc, f_nak;
  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;
  logic [12:0] q[$];
  logic m_thresh, m_ovf;

  always #5 clk = ~clk;

  i2c_fmt_fifo dut (
    .clk_i(clk), .rst_i(rst_i), .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i),
    .flush_i(flush_i), .thresh_i(thresh_i), .fmt_fifo_rvalid_o(rvalid), .fmt_fifo_rready_i(rready),
    .fmt_fifo_depth_o(depth_o), .fmt_byte_o(byte_o), .fmt_flag_start_before_o(f_start),
    .fmt_flag_stop_after_o(f_stop), .fmt_flag_read_bytes_o(f_rb), .fmt_flag_read_continue_o(f_rc),
    .fmt_flag_nak_ok_o(f_nak), .thresh_o(thresh_o), .overflow_o(overflow_o)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [12:0] dut_head();
    return {f_nak, f_rc, f_rb, f_stop, f_start, byte_o};
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      q.delete();
      m_thresh = 0;
      m_ovf = 0;
    end else if (flush_i) begin
      q.delete();
      m_ovf = 0;
      m_thresh = 0 < thresh_i;
    end else begin
      bit is_full, do_pop;
      is_full = q.size() == 64;
      do_pop = q.size() != 0 && rready;
      m_ovf = wvalid_i && is_full;
      if (do_pop) void'(q.pop_front());
      if (wvalid_i && !is_full) q.push_back(wdata_i);
      m_thresh = q.size() < int'(thresh_i);
    end
    cmp_en = 1;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("wready", 16'(wready_o), 16'(!rst_i && !flush_i && q.size() != 64));
      chk("rvalid", 16'(rvalid), 16'(q.size() != 0));
      chk("depth", 16'(depth_o), 16'(q.size()));
      chk("head", 16'(dut_head()), 16'(q.size() != 0 ? q[0] : 13'd0));
      chk("thresh", 16'(thresh_o), 16'(m_thresh));
      chk("overflow", 16'(overflow_o), 16'(m_ovf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1; wvalid_i = 1; wdata_i = 0; flush_i = 0; rready = 0; thresh_i = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_wready", 16'(wready_o), 16'd0);
    chk("rst_rvalid", 16'(rvalid), 16'd0);
    chk("rst_depth", 16'(depth_o), 16'd0);
    chk("rst_thresh", 16'(thresh_o), 16'd0);
    chk("rst_ovf", 16'(overflow_o), 16'd0);
    step();
    rst_i = 0; wvalid_i = 0;
    @(negedge clk);
    chk("post_rst_wready", 16'(wready_o), 16'd1);
    step();
    for (int i = 0; i < 64; i++) begin
      wvalid_i = 1;
      wdata_i = {3'b000, 1'(i == 63), 1'(i == 0), 8'(i)};
      step();
    end
    wvalid_i = 0;
    @(negedge clk);
    chk("full_depth", 16'(depth_o), 16'd64);
    chk("full_wready", 16'(wready_o), 16'd0);
    step();
    wvalid_i = 1; wdata_i = 13'h0ff;
    step();
    wvalid_i = 0;
    @(negedge clk);
    chk("ovf_pulse", 16'(overflow_o), 16'd1);
    step();
    @(negedge clk);
    chk("ovf_clear", 16'(overflow_o), 16'd0);
    step();
    rready = 1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("drain_byte", 16'(byte_o), 16'(i));
      chk("drain_start", 16'(f_start), 16'(i == 0));
      chk("drain_stop", 16'(f_stop), 16'(i == 63));
      step();
    end
    @(negedge clk);
    chk("drain_empty", 16'(rvalid), 16'd0);
    step();
    rready = 0;
    for (int k = 0; k < 205; k++) begin
      wvalid_i = 1;
      wdata_i = 13'(k);
      rready = k >= 5;
      step();
    end
    wvalid_i = 0; rready = 0;
    @(negedge clk);
    chk("stream_depth", 16'(depth_o), 16'd5);
    chk("stream_head", 16'(dut_head()), 16'd200);
    step();
    rready = 1;
    repeat (5) step();
    rready = 0;
    for (int k = 0; k < 10; k++) begin
      wvalid_i = 1;
      wdata_i = 13'h1000 | 13'(k);
      step();
    end
    wvalid_i = 0;
    @(negedge clk);
    chk("pre_flush_depth", 16'(depth_o), 16'd10);
    step();
    flush_i = 1; wvalid_i = 1; rready = 1; wdata_i = 13'h1ab;
    @(negedge clk);
    chk("flush_wready", 16'(wready_o), 16'd0);
    step();
    flush_i = 0; wvalid_i = 0; rready = 0;
    @(negedge clk);
    chk("flush_depth", 16'(depth_o), 16'd0);
    chk("flush_rvalid", 16'(rvalid), 16'd0);
    chk("flush_ovf", 16'(overflow_o), 16'd0);
    chk("flush_byte", 16'(byte_o), 16'd0);
    step();
    thresh_i = 4;
    for (int k = 0; k < 3; k++) begin
      wvalid_i = 1;
      wdata_i = 13'(8'h40 + k);
      step();
    end
    wvalid_i = 0;
    @(negedge clk);
    chk("wm_below", 16'(thresh_o), 16'd1);
    step();
    wvalid_i = 1; wdata_i = 13'h043;
    step();
    wvalid_i = 0;
    @(negedge clk);
    chk("wm_reached", 16'(thresh_o), 16'd0);
    step();
    thresh_i = 0; rready = 1;
    repeat (4) step();
    rready = 0;
    @(negedge clk);
    chk("wm_zero", 16'(thresh_o), 16'd0);
    chk("wm_drained", 16'(depth_o), 16'd0);
    step();
    wvalid_i = 1; rready = 1; wdata_i = 13'h155;
    @(negedge clk);
    chk("fwft_n_rvalid", 16'(rvalid), 16'd0);
    step();
    wvalid_i = 0;
    @(negedge clk);
    chk("fwft_rvalid", 16'(rvalid), 16'd1);
    chk("fwft_head", 16'(dut_head()), 16'h155);
    step();
    rready = 0;
    @(negedge clk);
    chk("fwft_popped", 16'(rvalid), 16'd0);
    chk("fwft_depth", 16'(depth_o), 16'd0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
